// File: rtl/io_response_checker.sv
// io_response_checker
// Response end of the vector test harness. Expected vectors are queued
// in a small FIFO. Each stim_fire accepted during a run becomes a compare
// LATENCY cycles later. At that compare, io_z is checked against the FIFO
// head under its mask. The block counts vectors and errors and keeps a
// copy of the first failing compare.
//
// state | meaning
// IDLE  | after reset, no run active
// RUN   | checking, stim_fire tokens accepted
// DONE  | last vector compared, pass/fail valid
module io_response_checker #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [WIDTH-1:0] exp_mask,
  input  logic             exp_last,
  input  logic             stim_fire,
  input  logic [WIDTH-1:0] io_z,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic             underflow,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   fifo_data [DEPTH];
  logic [WIDTH-1:0]   fifo_mask [DEPTH];
  logic [DEPTH-1:0]   fifo_last;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic [LATENCY-1:0] dly;

  logic             push;
  logic             pop;
  logic             cmp;
  logic             fifo_empty;
  logic [WIDTH-1:0] head_data;
  logic [WIDTH-1:0] head_mask;
  logic             head_last;
  logic             mismatch;
  logic             err;
  logic [AW:0]      count_nx;
  logic [CNT_W-1:0] vec_count_nx;
  logic [CNT_W-1:0] err_count_nx;

  // FIFO handshake, compare decode and saturating counter next values
  always_comb begin
    push       = exp_valid && exp_ready;
    fifo_empty = (count == '0);
    cmp        = (state == RUN) && dly[LATENCY-1];
    pop        = cmp && !fifo_empty;
    head_data  = fifo_data[rd_ptr];
    head_mask  = fifo_mask[rd_ptr];
    head_last  = fifo_last[rd_ptr];
    mismatch   = |((io_z ^ head_data) & head_mask);
    err        = cmp && (fifo_empty || mismatch);
    count_nx   = count + (AW+1)'(push) - (AW+1)'(pop);
    vec_count_nx = vec_count;
    if (cmp && (vec_count != '1)) vec_count_nx = vec_count + CNT_W'(1);
    err_count_nx = err_count;
    if (err && (err_count != '1)) err_count_nx = err_count + CNT_W'(1);
  end

  // FIFO storage, written on an accepted push
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= exp_data;
      fifo_mask[wr_ptr] <= exp_mask;
      fifo_last[wr_ptr] <= exp_last;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      exp_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nx;
      exp_ready <= (count_nx != (AW+1)'(DEPTH));
    end
  end

  // run control, delay line, counters and first-error capture
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      dly           <= '0;
      busy          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      underflow     <= 1'b0;
      vec_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          dly <= '0;
          if (start) begin
            state         <= RUN;
            busy          <= 1'b1;
            pass          <= 1'b0;
            fail          <= 1'b0;
            underflow     <= 1'b0;
            vec_count     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
          end
        end
        RUN: begin
          dly[0] <= stim_fire;
          for (int i = 1; i < LATENCY; i++) dly[i] <= dly[i-1];
          if (cmp) begin
            vec_count <= vec_count_nx;
            err_count <= err_count_nx;
            if (fifo_empty) underflow <= 1'b1;
            if (err && (err_count == '0)) begin
              first_err_idx <= vec_count;
              first_err_exp <= fifo_empty ? '0 : (head_data & head_mask);
              first_err_got <= fifo_empty ? io_z : (io_z & head_mask);
            end
            // Tokens still in flight when the last vector lands are dropped.
            if (pop && head_last) begin
              state <= DONE;
              busy  <= 1'b0;
              dly   <= '0;
              pass  <= (err_count_nx == '0);
              fail  <= (err_count_nx != '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_response_checker.sv
// Directed bench for io_response_checker with hand-computed expectations.
module tb_io_response_checker;

  logic        clock = 1'b0;
  logic        reset, start, exp_valid, exp_last, stim_fire;
  logic [15:0] exp_data, exp_mask, io_z;
  logic        exp_ready, busy, pass, fail, underflow;
  logic [15:0] vec_count, err_count, first_err_idx, first_err_exp, first_err_got;

  int checks   = 0;
  int failures = 0;
  logic [15:0] zv [0:7];

  io_response_checker dut (
    .clock(clock), .reset(reset), .start(start),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
    .exp_mask(exp_mask), .exp_last(exp_last), .stim_fire(stim_fire),
    .io_z(io_z), .busy(busy), .pass(pass), .fail(fail),
    .underflow(underflow), .vec_count(vec_count), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_exp(first_err_exp),
    .first_err_got(first_err_got)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [15:0] m, input logic l);
    exp_valid = 1'b1; exp_data = d; exp_mask = m; exp_last = l;
    tick();
    exp_valid = 1'b0; exp_last = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n fires back to back; io_z for fire k is presented one cycle later
  task automatic drive(input int n);
    for (int i = 0; i <= n; i++) begin
      stim_fire = (i < n);
      io_z      = (i > 0) ? zv[i-1] : 16'h0000;
      tick();
    end
    stim_fire = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; exp_valid = 1'b0; exp_last = 1'b0;
    stim_fire = 1'b0; exp_data = '0; exp_mask = '0; io_z = '0;
    tick();
    tick();
    chk("rst_ready", exp_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vec", vec_count, 0);
    chk("rst_pass", pass, 0);
    reset = 1'b0;
    tick();
    chk("rel_ready", exp_ready, 1);

    // 1: preloaded all-match run
    push(16'h0003, 16'hFFFF, 1'b0);
    push(16'h0007, 16'hFFFF, 1'b0);
    push(16'h000F, 16'hFFFF, 1'b1);
    do_start();
    chk("t1_busy_run", busy, 1);
    zv[0] = 16'h0003; zv[1] = 16'h0007; zv[2] = 16'h000F;
    drive(3);
    chk("t1_pass", pass, 1);
    chk("t1_fail", fail, 0);
    chk("t1_vec", vec_count, 3);
    chk("t1_err", err_count, 0);
    chk("t1_busy", busy, 0);
    stim_fire = 1'b1; tick(); tick(); stim_fire = 1'b0; tick();
    chk("t1_done_ignore", vec_count, 3);

    // 2: one mismatching bit in the last vector
    push(16'h1111, 16'hFFFF, 1'b0);
    push(16'h1234, 16'hFFFF, 1'b1);
    do_start();
    chk("t2_pass_clr", pass, 0);
    chk("t2_vec_clr", vec_count, 0);
    zv[0] = 16'h1111; zv[1] = 16'h1235;
    drive(2);
    chk("t2_fail", fail, 1);
    chk("t2_pass", pass, 0);
    chk("t2_err", err_count, 1);
    chk("t2_idx", first_err_idx, 1);
    chk("t2_exp", first_err_exp, 16'h1234);
    chk("t2_got", first_err_got, 16'h1235);

    // 3: masked-off bits differ
    push(16'h00FF, 16'h00FF, 1'b1);
    do_start();
    zv[0] = 16'hABFF;
    drive(1);
    chk("t3_pass", pass, 1);
    chk("t3_err", err_count, 0);
    chk("t3_vec", vec_count, 1);
    chk("t3_first_clr", first_err_got, 0);

    // 4: compare with empty FIFO
    do_start();
    zv[0] = 16'h5A5A;
    drive(1);
    chk("t4_underflow", underflow, 1);
    chk("t4_err", err_count, 1);
    chk("t4_vec", vec_count, 1);
    chk("t4_idx", first_err_idx, 0);
    chk("t4_exp", first_err_exp, 0);
    chk("t4_got", first_err_got, 16'h5A5A);
    chk("t4_busy", busy, 1);

    // 5: fill FIFO, reject ninth push, drain
    do_reset();
    chk("t5_rst_got", first_err_got, 0);
    chk("t5_rst_uf", underflow, 0);
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i), 16'hFFFF, (i == 7));
    chk("t5_full", exp_ready, 0);
    push(16'hDEAD, 16'hFFFF, 1'b1);
    chk("t5_still_full", exp_ready, 0);
    do_start();
    zv[0] = 16'h0100;
    drive(1);
    chk("t5_ready_after_pop", exp_ready, 1);
    chk("t5_vec1", vec_count, 1);
    for (int i = 0; i < 7; i++) zv[i] = 16'h0101 + 16'(i);
    drive(7);
    chk("t5_pass", pass, 1);
    chk("t5_vec", vec_count, 8);
    chk("t5_err", err_count, 0);

    // 6: reset in the middle of a run
    do_reset();
    for (int i = 0; i < 4; i++) push(16'h0020 + 16'(i), 16'hFFFF, (i == 3));
    do_start();
    zv[0] = 16'h0020; zv[1] = 16'h0021;
    drive(2);
    chk("t6_vec_mid", vec_count, 2);
    chk("t6_busy_mid", busy, 1);
    reset = 1'b1;
    tick();
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_vec", vec_count, 0);
    chk("t6_rst_ready", exp_ready, 0);
    reset = 1'b0;
    tick();
    chk("t6_ready", exp_ready, 1);
    stim_fire = 1'b1; io_z = 16'hFFFF;
    tick(); tick(); tick();
    stim_fire = 1'b0;
    tick();
    chk("t6_idle_vec", vec_count, 0);
    chk("t6_idle_uf", underflow, 0);
    do_start();
    zv[0] = 16'h0001;
    drive(1);
    chk("t6_empty_uf", underflow, 1);
    chk("t6_empty_err", err_count, 1);
    chk("t6_empty_got", first_err_got, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
